// File: rtl/bam_sequencer.sv
// Control FSM for the registered Booth multiplier wrapper: operand handshake, settle window,
// product capture and a held result-valid flag until the consumer takes it.
module bam_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             enable_a,
   output logic             enable_b,
   output logic             enable_out,
   output logic             reset_a,
   output logic             reset_b,
   output logic             reset_out,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {StIdle, StCompute, StCapture, StDone} state_e;

   localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [3:0]       settle_q, settle_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;
   logic             abort;

   assign abort    = reset | clear;
   assign op_count = op_count_q;

   always_comb begin
      state_d      = state_q;
      settle_d     = settle_q;
      op_count_d   = op_count_q;
      in_ready     = 1'b0;
      enable_a     = 1'b0;
      enable_b     = 1'b0;
      enable_out   = 1'b0;
      result_valid = 1'b0;
      reset_a      = abort;
      reset_b      = abort;
      reset_out    = abort;
      busy         = (state_q != StIdle) & ~reset;

      // Any abort wipes the wrapper regs, so no handshake or load may coincide with it.
      if (abort) begin
         state_d  = StIdle;
         settle_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  enable_a = 1'b1;
                  enable_b = 1'b1;
                  state_d  = StCompute;
                  settle_d = SettleLoad;
               end
            end
            StCompute: begin
               if (settle_q == 4'd0) begin
                  state_d = StCapture;
               end else begin
                  settle_d = settle_q - 4'd1;
               end
            end
            StCapture: begin
               enable_out = 1'b1;
               state_d    = StDone;
            end
            StDone: begin
               result_valid = 1'b1;
               if (result_ready) begin
                  op_count_d = op_count_q + CntOne;
                  state_d    = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         settle_q   <= '0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         op_count_q <= op_count_d;
      end
   end

endmodule

// File: tb/tb_bam_sequencer.sv
// Drives three sequencer instances (settle 2, 1 and 15; the last with a 4-bit counter) from
// shared stimulus and compares every output against a timeline model of each operation.
module tb_bam_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1;
   logic clear = 1'b0;
   logic in_valid = 1'b1;
   logic result_ready = 1'b0;

   logic in_ready [3];
   logic enable_a [3];
   logic enable_b [3];
   logic enable_out [3];
   logic reset_a [3];
   logic reset_b [3];
   logic reset_out [3];
   logic result_valid [3];
   logic busy [3];
   logic [15:0] cnt0, cnt1;
   logic [3:0]  cnt2;

   int unsigned settle_p [3] = '{2, 1, 15};
   int unsigned cnt_mod [3]  = '{65536, 65536, 16};

   int checks = 0;
   int errors = 0;

   bit active [3] = '{0, 0, 0};
   int age [3]    = '{0, 0, 0};
   int count [3]  = '{0, 0, 0};

   bam_sequencer #(.SETTLE_CYCLES(2), .CNT_W(16)) u_dut0 (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[0]),
      .enable_a(enable_a[0]), .enable_b(enable_b[0]), .enable_out(enable_out[0]),
      .reset_a(reset_a[0]), .reset_b(reset_b[0]), .reset_out(reset_out[0]),
      .result_valid(result_valid[0]), .result_ready(result_ready), .busy(busy[0]),
      .op_count(cnt0)
   );

   bam_sequencer #(.SETTLE_CYCLES(1), .CNT_W(16)) u_dut1 (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[1]),
      .enable_a(enable_a[1]), .enable_b(enable_b[1]), .enable_out(enable_out[1]),
      .reset_a(reset_a[1]), .reset_b(reset_b[1]), .reset_out(reset_out[1]),
      .result_valid(result_valid[1]), .result_ready(result_ready), .busy(busy[1]),
      .op_count(cnt1)
   );

   bam_sequencer #(.SETTLE_CYCLES(15), .CNT_W(4)) u_dut2 (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[2]),
      .enable_a(enable_a[2]), .enable_b(enable_b[2]), .enable_out(enable_out[2]),
      .reset_a(reset_a[2]), .reset_b(reset_b[2]), .reset_out(reset_out[2]),
      .result_valid(result_valid[2]), .result_ready(result_ready), .busy(busy[2]),
      .op_count(cnt2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // One cycle: drive inputs after the falling edge, compare, then advance the model.
   task automatic step(input bit r, input bit c, input bit v, input bit rr);
      @(negedge clk);
      reset = r;
      clear = c;
      in_valid = v;
      result_ready = rr;
      #1;
      for (int k = 0; k < 3; k++) begin
         bit live, e_acc, e_out, e_rv;
         int s;
         logic [31:0] obs_cnt;
         s       = int'(settle_p[k]);
         live    = !r && !c;
         e_acc   = live && !active[k] && v;
         e_out   = live && active[k] && (age[k] == s + 1);
         e_rv    = live && active[k] && (age[k] >= s + 2);
         obs_cnt = (k == 0) ? {16'd0, cnt0} : (k == 1) ? {16'd0, cnt1} : {28'd0, cnt2};
         check($sformatf("in_ready[%0d]", k), {31'd0, in_ready[k]}, {31'd0, live && !active[k]});
         check($sformatf("enable_a[%0d]", k), {31'd0, enable_a[k]}, {31'd0, e_acc});
         check($sformatf("enable_b[%0d]", k), {31'd0, enable_b[k]}, {31'd0, e_acc});
         check($sformatf("enable_out[%0d]", k), {31'd0, enable_out[k]}, {31'd0, e_out});
         check($sformatf("reset_lines[%0d]", k), {29'd0, reset_a[k], reset_b[k], reset_out[k]},
               (r || c) ? 32'd7 : 32'd0);
         check($sformatf("result_valid[%0d]", k), {31'd0, result_valid[k]}, {31'd0, e_rv});
         check($sformatf("busy[%0d]", k), {31'd0, busy[k]}, {31'd0, active[k] && !r});
         check($sformatf("op_count[%0d]", k), obs_cnt, count[k]);
         if (r) begin
            active[k] = 0;
            count[k]  = 0;
         end else if (c) begin
            active[k] = 0;
         end else if (e_acc) begin
            active[k] = 1;
            age[k]    = 1;
         end else if (active[k]) begin
            if (e_rv && rr) begin
               active[k] = 0;
               count[k]  = (count[k] + 1) % int'(cnt_mod[k]);
            end else if (age[k] < 1000) begin
               age[k]++;
            end
         end
      end
   endtask

   initial begin
      // Reset held two cycles with in_valid asserted.
      step(1, 0, 1, 0);
      step(1, 0, 1, 0);
      // Single op, then long backpressure before the result is taken.
      step(0, 0, 1, 0);
      repeat (22) step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      repeat (3) step(0, 0, 0, 0);
      // Back-to-back with the consumer always ready; enough for the 4-bit counter to wrap.
      repeat (330) step(0, 0, 1, 1);
      // Abort during compute, then clear with in_valid while idle.
      step(0, 1, 0, 1);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      repeat (20) step(0, 0, 0, 1);
      step(0, 1, 1, 1);
      step(0, 0, 0, 1);
      // Reset mid-operation.
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);
      step(1, 0, 0, 1);
      repeat (3) step(0, 0, 0, 0);
      // Randomised traffic with occasional aborts and resets.
      repeat (3000) begin
         step($urandom_range(199) == 0, $urandom_range(39) == 0, $urandom_range(1) == 1,
              $urandom_range(9) < 6);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
